ch_eq_ctrl: RTL and testbench

CH_EQ_CTRL -- requirements
Module: ch_eq_ctrl

---
 rtl/ch_eq_ctrl.sv | 107 ++++++++++
 tb/tb_ch_eq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ch_eq_ctrl.sv
// ch_eq_ctrl: estimates the channel from a block of pilots, then passes one frame of data
// symbols to the equalizer through a single skid-free output register.
module ch_eq_ctrl #(
    parameter int N = 4,
    parameter int M = 2,
    parameter int PILOT_LEN = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic [N-1:0] eq_data,
    output logic         eq_valid,
    input  logic         out_ready,
    output logic [M-1:0] chan,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int LG = $clog2(PILOT_LEN);
    localparam int AW = N + LG;
    localparam int SW = AW + M;
    localparam int DW = $clog2(FRAME_LEN + 1);
    localparam logic [SW-1:0] CMAX = SW'((64'd1 << M) - 64'd1);

    typedef enum logic [1:0] {IDLE, TRAIN, EQ, FIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] acc, sum;
    logic [LG-1:0] pcnt;
    logic [DW-1:0] dcnt;
    logic [SW-1:0] est;
    logic [M-1:0]  est_sat;
    logic          accept, drain, last_pilot, frame_full, est_zero, out_free;

    assign accept     = in_valid & in_ready;
    assign drain      = eq_valid & out_ready;
    assign out_free   = !eq_valid || out_ready;
    assign frame_full = dcnt == DW'(FRAME_LEN);
    // In TRAIN in_ready is constant 1, so in_valid alone marks an accepted pilot.
    assign last_pilot = state == TRAIN && in_valid && pcnt == LG'(PILOT_LEN - 1);
    assign sum        = acc + AW'(in_data);
    assign est        = SW'(sum >> LG);
    assign est_sat    = est > CMAX ? {M{1'b1}} : est[M-1:0];
    assign est_zero   = est_sat == '0;
    assign busy       = state != IDLE;
    assign done       = state == FIN;

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = TRAIN;
            TRAIN: begin
                in_ready = 1'b1;
                if (last_pilot) state_nxt = est_zero ? FIN : EQ;
            end
            EQ: begin
                in_ready = !frame_full && out_free;
                if (frame_full && out_free) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            pcnt     <= '0;
            dcnt     <= '0;
            chan     <= '0;
            eq_data  <= '0;
            eq_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                acc  <= '0;
                pcnt <= '0;
                dcnt <= '0;
                err  <= 1'b0;
            end
            if (state == TRAIN && in_valid) begin
                acc  <= sum;
                pcnt <= pcnt + 1'b1;
            end
            if (last_pilot) begin
                chan <= est_sat;
                err  <= est_zero;
            end
            if (state == EQ && accept) begin
                eq_data  <= in_data;
                eq_valid <= 1'b1;
                dcnt     <= dcnt + 1'b1;
            end else if (drain) begin
                eq_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ch_eq_ctrl.sv
// tb_ch_eq_ctrl: directed and randomized frames checked against a transaction-level model
// (pilot average with saturation, one-deep output register as a queue).
module tb_ch_eq_ctrl;
    localparam int N = 4;
    localparam int M = 2;
    localparam int PL = 4;
    localparam int FL = 16;

    logic         clk = 1'b0;
    logic         rst_n, start, in_valid, out_ready;
    logic [N-1:0] in_data;
    logic         in_ready, eq_valid, busy, done, err;
    logic [N-1:0] eq_data;
    logic [M-1:0] chan;

    int vectors = 0;
    int fails = 0;

    ch_eq_ctrl #(.N(N), .M(M), .PILOT_LEN(PL), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .eq_data(eq_data), .eq_valid(eq_valid), .out_ready(out_ready),
        .chan(chan), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // dmode 0: in_valid=1 with data 0,1,2..; 1: random valid and data.
    // rmode 0: out_ready=1; 1: out_ready pattern 1,0,0,1; 2: random.
    task automatic run_frame(input int p0, input int p1, input int p2, input int p3,
                             input int dmode, input int rmode, input bit hold);
        int p[4];
        int sum, e, ec, sent;
        int pend[$];
        bit exp_rdy, fin_now;
        p = '{p0, p1, p2, p3};
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        chk("train_busy", busy, 1);
        chk("train_err_clr", err, 0);
        chk("train_eq_valid", eq_valid, 0);
        sum = 0;
        for (int i = 0; i < PL; i++) begin
            in_valid = 1'b1;
            in_data  = N'(p[i]);
            #1;
            chk("train_in_ready", in_ready, 1);
            sum += p[i];
            tick();
        end
        e  = sum / PL;
        ec = e > (1 << M) - 1 ? (1 << M) - 1 : e;
        chk("chan", chan, ec);
        if (ec == 0) begin
            chk("zero_err", err, 1);
            chk("zero_done", done, 1);
            chk("zero_eq_valid", eq_valid, 0);
            chk("zero_in_ready", in_ready, 0);
            in_valid = 1'b0;
            tick();
            chk("zero_idle_busy", busy, 0);
            chk("zero_idle_done", done, 0);
            chk("zero_err_sticky", err, 1);
            return;
        end
        chk("est_err", err, 0);
        sent = 0;
        fin_now = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3)
                                                       : 1'($urandom_range(0, 1));
            in_valid  = dmode == 0 ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_data   = dmode == 0 ? N'(sent) : N'($urandom);
            #1;
            exp_rdy = sent < FL && (pend.size() == 0 || out_ready);
            chk("eq_in_ready", in_ready, exp_rdy);
            chk("eq_valid", eq_valid, pend.size() != 0);
            if (pend.size() != 0) chk("eq_data", eq_data, pend[0]);
            chk("eq_done", done, 0);
            fin_now = sent == FL && (pend.size() == 0 || out_ready);
            if (pend.size() != 0 && out_ready) void'(pend.pop_front());
            if (in_valid && exp_rdy) begin
                pend.push_back(int'(in_data));
                sent++;
            end
            tick();
            if (fin_now) break;
        end
        chk("fin_reached", fin_now, 1);
        chk("beats_sent", sent, FL);
        chk("fin_done", done, 1);
        chk("fin_eq_valid", eq_valid, 0);
        chk("fin_in_ready", in_ready, 0);
        chk("fin_err", err, 0);
        in_valid = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_chan_hold", chan, ec);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_eq_valid", eq_valid, 0);
        chk("rst_eq_data", eq_data, 0);
        chk("rst_chan", chan, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();

        run_frame(3, 3, 3, 3, 0, 0, 0);
        run_frame(0, 1, 0, 0, 0, 0, 0);
        run_frame(15, 15, 15, 15, 0, 0, 0);
        run_frame(4, 4, 4, 4, 0, 1, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < PL; i++) begin
            in_valid = 1'b1;
            in_data = 4'd2;
            tick();
        end
        chk("mid_chan", chan, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = N'(i + 1);
            tick();
        end
        chk("mid_eq_valid_pre", eq_valid, 1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_eq_valid", eq_valid, 0);
        chk("mid_rst_chan", chan, 0);
        chk("mid_rst_done", done, 0);
        tick();
        chk("mid_rst_done2", done, 0);
        chk("mid_rst_busy2", busy, 0);
        run_frame(8, 8, 8, 8, 0, 0, 0);

        run_frame(5, 6, 7, 8, 1, 2, 1);
        run_frame(9, 2, 1, 0, 1, 2, 1);
        start = 1'b0;

        for (int f = 0; f < 6; f++)
            run_frame($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                      $urandom_range(0, 15), 1, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
